// File: rtl/add_one_arb_pkg.sv
// Shared defaults and types for the add_one round-robin arbiter.
package add_one_arb_pkg;

    localparam int NUM_REQ_DFLT = 4;
    localparam int DATA_W_DFLT  = 32;
    localparam int DEPTH_DFLT   = 4;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAG_W_DFLT = tag_w(NUM_REQ_DFLT);

    typedef logic [TAG_W_DFLT-1:0] tag_t;

    typedef struct packed {
        logic                   vld;
        logic [DATA_W_DFLT-1:0] data;
        tag_t                   tag;
    } iss_t;

endpackage

// File: rtl/add_one_tag_fifo.sv
// In-order FIFO of requester tags for outstanding add_one operations.
module add_one_tag_fifo
    import add_one_arb_pkg::*;
#(
    parameter int TAG_W = TAG_W_DFLT,
    parameter int DEPTH = DEPTH_DFLT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   diff;
    logic [TAG_W-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Extra wrap bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = mem[rd_ptr[PTR_W-1:0]];
    assign diff  = wr_ptr - rd_ptr;
    assign count = CNT_W'(diff);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_tag;
    end

endmodule

// File: rtl/add_one_arbiter.sv
// Round-robin arbiter sharing one add_one datapath among NUM_REQ requesters.
module add_one_arbiter
    import add_one_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DFLT,
    parameter int DATA_W  = DATA_W_DFLT,
    parameter int DEPTH   = DEPTH_DFLT,
    localparam int TAG_W  = tag_w(NUM_REQ),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_vld,
    output logic [NUM_REQ-1:0]      req_busy,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      rsp_vld,
    input  logic [NUM_REQ-1:0]      rsp_busy,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    add_one_x_vld,
    input  logic                    add_one_x_busy,
    output logic [DATA_W-1:0]       add_one_x_data,
    input  logic                    add_one_return_vld,
    output logic                    add_one_return_busy,
    input  logic [DATA_W-1:0]       add_one_return_data,
    output logic [CNT_W-1:0]        outstanding,
    output logic                    err_orphan
);

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } iss_reg_t;

    iss_reg_t          iss;
    logic [TAG_W-1:0]  rr_ptr;
    logic [TAG_W-1:0]  rr_next;
    logic [TAG_W-1:0]  winner;
    logic [TAG_W-1:0]  cand;
    logic [DATA_W-1:0] win_data;
    logic              found;
    logic              load;
    logic              iss_free;
    logic              pop;
    logic [TAG_W-1:0]  head;
    logic              tag_empty;
    logic              tag_full;
    int                idx;

    // Priority scan starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = TAG_W'(idx);
            if (!found && req_vld[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == TAG_W'(i)) win_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign rr_next  = (winner == TAG_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign iss_free = ~iss.vld | ~add_one_x_busy;
    assign load     = rst & iss_free & ~tag_full & found;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_busy[i] = !(load && (winner == TAG_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            iss        <= '0;
            rr_ptr     <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (load) begin
                iss.vld  <= 1'b1;
                iss.data <= win_data;
                iss.tag  <= winner;
                rr_ptr   <= rr_next;
            end else if (iss.vld && !add_one_x_busy) begin
                iss.vld <= 1'b0;
            end
            if (add_one_return_vld && tag_empty) err_orphan <= 1'b1;
        end
    end

    assign add_one_x_vld  = iss.vld;
    assign add_one_x_data = iss.data;

    // Orphan returns see busy=0 and are dropped.
    assign add_one_return_busy = ~rst | (~tag_empty & rsp_busy[head]);
    assign pop = add_one_return_vld & ~add_one_return_busy & ~tag_empty;
    assign rsp_data = add_one_return_data;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_vld[i] = rst && add_one_return_vld && !tag_empty &&
                         (head == TAG_W'(i));
        end
    end

    add_one_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (load),
        .push_tag (winner),
        .pop      (pop),
        .head     (head),
        .empty    (tag_empty),
        .full     (tag_full),
        .count    (outstanding)
    );

endmodule

// File: tb/tb_add_one_arbiter.sv
// Directed scoreboard bench for add_one_arbiter; the bench models add_one.
module tb_add_one_arbiter;
    import add_one_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vld;
    logic [N-1:0]   req_busy;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   rsp_vld;
    logic [N-1:0]   rsp_busy;
    logic [W-1:0]   rsp_data;
    logic           x_vld;
    logic           x_busy;
    logic [W-1:0]   x_data;
    logic           ret_vld;
    logic           ret_busy;
    logic [W-1:0]   ret_data;
    logic [2:0]     outstanding;
    logic           err_orphan;

    typedef struct {
        tag_t         tag;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] addq[$];
    int           grants[$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    add_one_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_vld             (req_vld),
        .req_busy            (req_busy),
        .req_data            (req_data),
        .rsp_vld             (rsp_vld),
        .rsp_busy            (rsp_busy),
        .rsp_data            (rsp_data),
        .add_one_x_vld       (x_vld),
        .add_one_x_busy      (x_busy),
        .add_one_x_data      (x_data),
        .add_one_return_vld  (ret_vld),
        .add_one_return_busy (ret_busy),
        .add_one_return_data (ret_data),
        .outstanding         (outstanding),
        .err_orphan          (err_orphan)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    task automatic drive_ret();
        ret_vld  = (addq.size() > 0);
        ret_data = '0;
        if (addq.size() > 0) ret_data = addq[0] + 32'd1;
    endtask

    // Record handshakes just before the edge, then advance one cycle.
    task automatic cyc();
        exp_t e;
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_vld[i] && !req_busy[i]) begin
                e.tag  = tag_t'(i);
                e.data = req_data[i*W +: W] + 32'd1;
                sb.push_back(e);
                grants.push_back(i);
            end
        end
        if (x_vld && !x_busy) addq.push_back(x_data);
        if (ret_vld && !ret_busy && sb.size() > 0 && addq.size() > 0) begin
            e = sb.pop_front();
            void'(addq.pop_front());
            check("rsp_vld", 32'(rsp_vld), 32'(1) << e.tag);
            check("rsp_data", rsp_data, e.data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            drive_ret();
            cyc();
        end
        ret_vld = 1'b0;
        check("drain_empty", sb.size(), 0);
        check("drain_outst", outstanding, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        req_vld  = '0;
        req_data = '0;
        rsp_busy = '0;
        x_busy   = 1'b0;
        ret_vld  = 1'b0;
        ret_data = '0;

        // Reset
        @(posedge clk);
        #1;
        req_vld = 4'hF;
        #1;
        check("rst_req_busy", req_busy, 4'hF);
        @(posedge clk);
        #1;
        check("rst_x_vld", x_vld, 0);
        check("rst_x_data", x_data, 0);
        check("rst_ret_busy", ret_busy, 1);
        check("rst_outst", outstanding, 0);
        check("rst_err", err_orphan, 0);
        check("rst_rsp_vld", rsp_vld, 0);
        req_vld = '0;
        rst = 1'b1;

        // Fairness
        grants.delete();
        req_vld = 4'hF;
        for (int c = 0; c < 40 && grants.size() < 8; c++) begin
            for (int i = 0; i < N; i++) set_data(i, $urandom);
            drive_ret();
            cyc();
        end
        req_vld = '0;
        drain();
        check("fair_grants", grants.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fair_order%0d", k),
                  (k < grants.size()) ? grants[k] : -1, k % N);
        end

        // Single request from requester 2
        grants.delete();
        set_data(2, 32'h9);
        req_vld = 4'b0100;
        #1;
        check("one_req_busy", req_busy, 4'b1011);
        cyc();
        req_vld = '0;
        check("one_x_vld", x_vld, 1);
        check("one_x_data", x_data, 32'h9);
        check("one_outst1", outstanding, 1);
        cyc();
        check("one_x_drain", x_vld, 0);
        drive_ret();
        #1;
        check("one_rsp_vld", rsp_vld, 4'b0100);
        check("one_rsp_data", rsp_data, 32'hA);
        cyc();
        ret_vld = 1'b0;
        check("one_outst0", outstanding, 0);

        // Full
        grants.delete();
        req_vld = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            set_data(0, 32'h20 + c);
            cyc();
        end
        check("full_accepts", grants.size(), 4);
        check("full_outst", outstanding, 4);
        #1;
        check("full_busy", req_busy, 4'hF);
        cyc();
        check("full_hold", grants.size(), 4);
        drive_ret();
        #1;
        check("full_pop_busy", req_busy, 4'hF);
        check("full_ret_busy", ret_busy, 0);
        cyc();
        ret_vld = 1'b0;
        check("full_outst3", outstanding, 3);
        #1;
        check("full_next_busy", req_busy, 4'b1110);
        cyc();
        check("full_outst4", outstanding, 4);
        req_vld = '0;
        drain();

        // Backpressure on both channels
        grants.delete();
        x_busy = 1'b1;
        set_data(3, 32'h55);
        req_vld = 4'b1000;
        cyc();
        check("bp_x_vld", x_vld, 1);
        set_data(3, 32'h66);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_req_busy", req_busy, 4'hF);
            check("bp_x_data", x_data, 32'h55);
            cyc();
        end
        check("bp_one_load", grants.size(), 1);
        req_vld = '0;
        x_busy = 1'b0;
        cyc();
        rsp_busy = 4'b1000;
        drive_ret();
        #1;
        check("bp_ret_busy", ret_busy, 1);
        check("bp_rsp_vld", rsp_vld, 4'b1000);
        cyc();
        check("bp_no_pop", outstanding, 1);
        rsp_busy = 4'b0111;
        #1;
        check("bp_other_busy", ret_busy, 0);
        cyc();
        ret_vld = 1'b0;
        rsp_busy = '0;
        check("bp_outst0", outstanding, 0);

        // Orphan return
        ret_vld = 1'b1;
        ret_data = 32'h77;
        #1;
        check("orph_ret_busy", ret_busy, 0);
        check("orph_rsp_vld", rsp_vld, 0);
        cyc();
        ret_vld = 1'b0;
        check("orph_err", err_orphan, 1);
        cyc();
        cyc();
        check("orph_sticky", err_orphan, 1);
        check("orph_outst", outstanding, 0);

        // Reset with three requests outstanding
        grants.delete();
        set_data(1, 32'h31);
        req_vld = 4'b0010;
        for (int c = 0; c < 3; c++) cyc();
        check("mr_outst3", outstanding, 3);
        rst = 1'b0;
        req_vld = 4'b0110;
        #1;
        check("mr_busy", req_busy, 4'hF);
        cyc();
        check("mr_outst0", outstanding, 0);
        check("mr_x_vld", x_vld, 0);
        check("mr_err", err_orphan, 0);
        sb.delete();
        addq.delete();
        grants.delete();
        rst = 1'b1;
        set_data(1, 32'hFFFF_FFFF);
        set_data(2, 32'h22);
        #1;
        check("mr_first_grant", req_busy, 4'b1101);
        cyc();
        req_vld = '0;
        check("mr_x_data", x_data, 32'hFFFF_FFFF);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
